// File: rtl/tinycpu_pkg.sv
// Shared definitions for the tinycpu boot loader: loader state encoding and
// word/byte packing constants.
package tinycpu_pkg;

    localparam int LOADER_BYTES_PER_WORD = 2;

    typedef enum logic [3:0] {
        IDLE   = 4'd0,
        CNT_HI = 4'd1,
        CNT_LO = 4'd2,
        DAT_HI = 4'd3,
        DAT_LO = 4'd4,
        WRITE  = 4'd5,
        CHK    = 4'd6,
        DONE   = 4'd7,
        ERR    = 4'd8
    } loader_state_t;

    function automatic logic accepts_bytes(input loader_state_t s);
        logic r;
        case (s)
            CNT_HI, CNT_LO, DAT_HI, DAT_LO, CHK: r = 1'b1;
            default:                             r = 1'b0;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/ram_loader_fsm.sv
// Loader sequencer: header count, big-endian word assembly, write addressing
// and XOR checksum. Status outputs are registered from the next state.
module ram_loader_fsm
    import tinycpu_pkg::*;
#(
    parameter int DWIDTH = 16,
    parameter int AWIDTH = 12,
    parameter int WORDS  = 4096
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_start,
    input  logic              i_in_valid,
    input  logic [7:0]        i_in_data,
    output logic              o_in_ready,
    output logic              o_cpu_hold,
    output logic              o_done,
    output logic              o_err,
    output logic              o_passthru,
    output logic              o_write,
    output logic [AWIDTH-1:0] o_waddr,
    output logic [DWIDTH-1:0] o_word
);

    localparam logic [16:0] WORDS_LIM = 17'(WORDS);

    loader_state_t r_state;
    loader_state_t w_state_nxt;
    logic [15:0]   r_count;
    logic [15:0]   w_count_nxt;
    logic [15:0]   w_cnt_full;
    logic [AWIDTH:0] r_waddr;
    logic [AWIDTH:0] w_waddr_nxt;
    logic [8*LOADER_BYTES_PER_WORD-1:0] r_word;
    logic [8*LOADER_BYTES_PER_WORD-1:0] w_word_nxt;
    logic [7:0]    r_chk;
    logic [7:0]    w_chk_nxt;
    logic          r_in_ready;
    logic          r_cpu_hold;
    logic          r_done;
    logic          r_err;
    logic          w_accept;

    assign w_accept   = i_in_valid & r_in_ready;
    assign w_cnt_full = {r_count[15:8], i_in_data};

    // Next-state and datapath update for one loader step
    always_comb begin
        w_state_nxt = r_state;
        w_count_nxt = r_count;
        w_waddr_nxt = r_waddr;
        w_word_nxt  = r_word;
        w_chk_nxt   = r_chk;
        case (r_state)
            IDLE, DONE, ERR: begin
                if (i_start) begin
                    w_state_nxt = CNT_HI;
                    w_waddr_nxt = '0;
                    w_chk_nxt   = 8'h00;
                end else begin
                    w_state_nxt = r_state;
                end
            end
            CNT_HI: begin
                if (w_accept) begin
                    w_count_nxt = {i_in_data, r_count[7:0]};
                    w_state_nxt = CNT_LO;
                end else begin
                    w_state_nxt = r_state;
                end
            end
            CNT_LO: begin
                if (w_accept) begin
                    w_count_nxt = w_cnt_full;
                    if ({1'b0, w_cnt_full} > WORDS_LIM) begin
                        w_state_nxt = ERR;
                    end else if (w_cnt_full == 16'h0000) begin
                        w_state_nxt = CHK;
                    end else begin
                        w_state_nxt = DAT_HI;
                    end
                end else begin
                    w_state_nxt = r_state;
                end
            end
            DAT_HI: begin
                if (w_accept) begin
                    w_word_nxt[15:8] = i_in_data;
                    w_chk_nxt        = r_chk ^ i_in_data;
                    w_state_nxt      = DAT_LO;
                end else begin
                    w_state_nxt = r_state;
                end
            end
            DAT_LO: begin
                if (w_accept) begin
                    w_word_nxt[7:0] = i_in_data;
                    w_chk_nxt       = r_chk ^ i_in_data;
                    w_state_nxt     = WRITE;
                end else begin
                    w_state_nxt = r_state;
                end
            end
            WRITE: begin
                w_waddr_nxt = r_waddr + {{AWIDTH{1'b0}}, 1'b1};
                w_count_nxt = r_count - 16'd1;
                if (r_count == 16'h0001) begin
                    w_state_nxt = CHK;
                end else begin
                    w_state_nxt = DAT_HI;
                end
            end
            CHK: begin
                if (w_accept) begin
                    if (i_in_data == r_chk) begin
                        w_state_nxt = DONE;
                    end else begin
                        w_state_nxt = ERR;
                    end
                end else begin
                    w_state_nxt = r_state;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    // State, datapath and registered status outputs
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state    <= IDLE;
            r_count    <= 16'h0000;
            r_waddr    <= '0;
            r_word     <= '0;
            r_chk      <= 8'h00;
            r_in_ready <= 1'b0;
            r_cpu_hold <= 1'b0;
            r_done     <= 1'b0;
            r_err      <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_count    <= w_count_nxt;
            r_waddr    <= w_waddr_nxt;
            r_word     <= w_word_nxt;
            r_chk      <= w_chk_nxt;
            r_in_ready <= accepts_bytes(w_state_nxt);
            r_cpu_hold <= (w_state_nxt != IDLE) && (w_state_nxt != DONE);
            r_done     <= (w_state_nxt == DONE);
            r_err      <= (w_state_nxt == ERR);
        end
    end

    assign o_in_ready = r_in_ready;
    assign o_cpu_hold = r_cpu_hold;
    assign o_done     = r_done;
    assign o_err      = r_err;
    assign o_passthru = (r_state == IDLE) || (r_state == DONE);
    // The MSB guard never masks a legal write; it only blocks an overrun address.
    assign o_write    = (r_state == WRITE) && !r_waddr[AWIDTH];
    assign o_waddr    = r_waddr[AWIDTH-1:0];
    assign o_word     = r_word;

endmodule

// File: rtl/ram_loader.sv
// Boot-time program loader owning the RAM write port; the CPU port is passed
// through whenever no load is in progress.
module ram_loader
    import tinycpu_pkg::*;
#(
    parameter int DWIDTH = 16,
    parameter int AWIDTH = 12,
    parameter int WORDS  = 4096
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              in_valid,
    input  logic [7:0]        in_data,
    output logic              in_ready,
    input  logic              cpu_load,
    input  logic [AWIDTH-1:0] cpu_addr,
    input  logic [DWIDTH-1:0] cpu_d,
    output logic              mem_load,
    output logic [AWIDTH-1:0] mem_addr,
    output logic [DWIDTH-1:0] mem_d,
    output logic              cpu_hold,
    output logic              done,
    output logic              err
);

    logic              w_passthru;
    logic              w_write;
    logic [AWIDTH-1:0] w_waddr;
    logic [DWIDTH-1:0] w_word;

    ram_loader_fsm #(
        .DWIDTH (DWIDTH),
        .AWIDTH (AWIDTH),
        .WORDS  (WORDS)
    ) u_fsm (
        .i_clk      (clk),
        .i_rst      (reset),
        .i_start    (start),
        .i_in_valid (in_valid),
        .i_in_data  (in_data),
        .o_in_ready (in_ready),
        .o_cpu_hold (cpu_hold),
        .o_done     (done),
        .o_err      (err),
        .o_passthru (w_passthru),
        .o_write    (w_write),
        .o_waddr    (w_waddr),
        .o_word     (w_word)
    );

    // RAM write-port mux: CPU owns the port unless a load is active
    always_comb begin
        if (w_passthru) begin
            mem_load = cpu_load;
            mem_addr = cpu_addr;
            mem_d    = cpu_d;
        end else begin
            mem_load = w_write;
            mem_addr = w_waddr;
            mem_d    = w_word;
        end
    end

endmodule

// File: tb/tb_ram_loader.sv
// Self-checking bench for ram_loader: vector table of byte streams, a write
// scoreboard, and hand sequences for passthrough, max count and async reset.
module tb_ram_loader;

    logic        clk;
    logic        reset;
    logic        start;
    logic        in_valid;
    logic [7:0]  in_data;
    logic        in_ready;
    logic        cpu_load;
    logic [11:0] cpu_addr;
    logic [15:0] cpu_d;
    logic        mem_load;
    logic [11:0] mem_addr;
    logic [15:0] mem_d;
    logic        cpu_hold;
    logic        done;
    logic        err;

    ram_loader #(.DWIDTH(16), .AWIDTH(12), .WORDS(4096)) dut (
        .clk      (clk),
        .reset    (reset),
        .start    (start),
        .in_valid (in_valid),
        .in_data  (in_data),
        .in_ready (in_ready),
        .cpu_load (cpu_load),
        .cpu_addr (cpu_addr),
        .cpu_d    (cpu_d),
        .mem_load (mem_load),
        .mem_addr (mem_addr),
        .mem_d    (mem_d),
        .cpu_hold (cpu_hold),
        .done     (done),
        .err      (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [11:0] addr;
        logic [15:0] d;
    } wr_t;

    typedef struct {
        int         n;
        logic [7:0] b [10];
        logic       exp_done;
        logic       exp_err;
        int         gap;
        logic       cpu_noise;
    } vec_t;

    wr_t        sb[$];
    int         n_assert = 0;
    int         n_fail   = 0;
    logic       mon_en   = 1'b0;
    vec_t       vecs [7];
    logic [7:0] bq[$];

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_assert++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Write monitor: every loader write must match the next expected word
    always @(negedge clk) begin
        if (mon_en && mem_load && cpu_hold) begin
            check("ready_in_write", {31'd0, in_ready}, 32'd0);
            if (sb.size() == 0) begin
                check("unexpected_write", {20'd0, mem_addr}, 32'hFFFFFFFF);
            end else begin
                wr_t e;
                e = sb.pop_front();
                check("wr_addr", {20'd0, mem_addr}, {20'd0, e.addr});
                check("wr_data", {16'd0, mem_d}, {16'd0, e.d});
            end
        end
    end

    task automatic send_byte(input logic [7:0] b, output bit ok);
        ok       = 1'b0;
        in_valid = 1'b1;
        in_data  = b;
        for (int t = 0; t < 64; t++) begin
            if (in_ready) begin
                @(negedge clk);
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
        in_valid = 1'b0;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check("hold_after_start", {31'd0, cpu_hold}, 32'd1);
        check("done_cleared", {31'd0, done}, 32'd0);
        check("err_cleared", {31'd0, err}, 32'd0);
        check("ready_after_start", {31'd0, in_ready}, 32'd1);
    endtask

    task automatic run_stream(input string nm, input logic exp_done, input logic exp_err, input int gap);
        int cnt;
        bit ok;
        cnt = int'({bq[0], bq[1]});
        pulse_start();
        for (int i = 0; i < bq.size(); i++) begin
            if (gap > 0 && $urandom_range(99) < gap) begin
                repeat ($urandom_range(2, 1)) @(negedge clk);
            end
            if (cnt <= 4096 && i >= 3 && i < 2 + 2 * cnt && (i % 2) == 1) begin
                wr_t e;
                e.addr = 12'((i - 3) / 2);
                e.d    = {bq[i-1], bq[i]};
                sb.push_back(e);
            end
            send_byte(bq[i], ok);
            if (!ok) begin
                check({nm, "_byte_timeout"}, i, 32'hFFFFFFFF);
                return;
            end
        end
        for (int t = 0; t < 20 && !(done || err); t++) @(negedge clk);
        check({nm, "_done"}, {31'd0, done}, {31'd0, exp_done});
        check({nm, "_err"}, {31'd0, err}, {31'd0, exp_err});
        check({nm, "_hold"}, {31'd0, cpu_hold}, {31'd0, exp_err});
        check({nm, "_ready"}, {31'd0, in_ready}, 32'd0);
        check({nm, "_sb_empty"}, sb.size(), 32'd0);
        sb.delete();
    endtask

    task automatic load_vec(input int k);
        bq.delete();
        for (int i = 0; i < vecs[k].n; i++) bq.push_back(vecs[k].b[i]);
    endtask

    initial begin
        bit ok;
        logic [7:0] hi;
        logic [7:0] lo;
        logic [7:0] chk;

        vecs[0] = '{7, '{8'h00, 8'h02, 8'h12, 8'h34, 8'hAB, 8'hCD, 8'h40, 8'h00, 8'h00, 8'h00}, 1'b1, 1'b0, 0, 1'b0};
        vecs[1] = '{7, '{8'h00, 8'h02, 8'h12, 8'h34, 8'hAB, 8'hCD, 8'h41, 8'h00, 8'h00, 8'h00}, 1'b0, 1'b1, 0, 1'b0};
        vecs[2] = '{3, '{8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00}, 1'b1, 1'b0, 0, 1'b0};
        vecs[3] = '{2, '{8'h10, 8'h01, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00}, 1'b0, 1'b1, 0, 1'b0};
        vecs[4] = '{9, '{8'h00, 8'h03, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h00}, 1'b1, 1'b0, 40, 1'b0};
        vecs[5] = '{7, '{8'h00, 8'h02, 8'h12, 8'h34, 8'hAB, 8'hCD, 8'h40, 8'h00, 8'h00, 8'h00}, 1'b1, 1'b0, 30, 1'b1};
        vecs[6] = '{5, '{8'h00, 8'h01, 8'hFF, 8'h00, 8'hFF, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00}, 1'b1, 1'b0, 50, 1'b0};

        reset    = 1'b1;
        start    = 1'b0;
        in_valid = 1'b0;
        in_data  = 8'h00;
        cpu_load = 1'b0;
        cpu_addr = 12'h000;
        cpu_d    = 16'h0000;
        repeat (3) @(negedge clk);
        check("rst_ready", {31'd0, in_ready}, 32'd0);
        check("rst_hold", {31'd0, cpu_hold}, 32'd0);
        check("rst_done", {31'd0, done}, 32'd0);
        check("rst_err", {31'd0, err}, 32'd0);
        check("rst_mem_load", {31'd0, mem_load}, 32'd0);
        reset = 1'b0;
        @(negedge clk);
        mon_en = 1'b1;

        for (int k = 0; k < 7; k++) begin
            load_vec(k);
            if (vecs[k].cpu_noise) begin
                cpu_load = 1'b1;
                cpu_addr = 12'h005;
                cpu_d    = 16'hBEEF;
            end
            run_stream($sformatf("vec%0d", k), vecs[k].exp_done, vecs[k].exp_err, vecs[k].gap);
            cpu_load = 1'b0;
            if (k == 0) begin
                cpu_load = 1'b1;
                cpu_addr = 12'h005;
                cpu_d    = 16'hBEEF;
                #1;
                check("pass_load", {31'd0, mem_load}, 32'd1);
                check("pass_addr", {20'd0, mem_addr}, 32'h005);
                check("pass_d", {16'd0, mem_d}, 32'hBEEF);
                @(negedge clk);
                cpu_load = 1'b0;
            end
        end

        // Maximum count: last write lands on address 4095
        bq.delete();
        bq.push_back(8'h10);
        bq.push_back(8'h00);
        chk = 8'h00;
        for (int k = 0; k < 4096; k++) begin
            hi  = 8'(k) ^ 8'h5A;
            lo  = 8'(k >> 4) ^ 8'hC3;
            chk = chk ^ hi ^ lo;
            bq.push_back(hi);
            bq.push_back(lo);
        end
        bq.push_back(chk);
        run_stream("max_count", 1'b1, 1'b0, 0);

        // Async reset while waiting for the low data byte
        bq.delete();
        pulse_start();
        send_byte(8'h00, ok);
        send_byte(8'h02, ok);
        send_byte(8'h12, ok);
        #1;
        reset = 1'b1;
        #1;
        check("arst_ready", {31'd0, in_ready}, 32'd0);
        check("arst_hold", {31'd0, cpu_hold}, 32'd0);
        check("arst_done", {31'd0, done}, 32'd0);
        check("arst_err", {31'd0, err}, 32'd0);
        check("arst_mem_load", {31'd0, mem_load}, 32'd0);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        load_vec(0);
        run_stream("after_rst", 1'b1, 1'b0, 20);

        mon_en = 1'b0;
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
